// File: rtl/async_lreq_source.sv
// Purpose: clocked FIFO-buffered source that emits each word as a 4-phase RZ bundled-data token (Ldata, Lreq / Lack).
// Latency: word into empty FIFO -> Ldata next cycle, Lreq SETUP_CYCLES later; min token period 1+SETUP_CYCLES+2*(SYNC_STAGES+1).
// Backpressure: in_ready = !full from registered count; the handshake waits on Lack indefinitely. Optional LREQ_TIMEOUT_EN adds a sticky watchdog.
module async_lreq_source #(
    parameter int DW           = 8,
    parameter int DEPTH        = 4,
    parameter int SETUP_CYCLES = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          Lreq,
    output logic [DW-1:0] Ldata,
    input  logic          Lack,
    output logic          busy,
    output logic [15:0]   tok_cnt,
    output logic          proto_err,
    output logic          timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        REQ_HI = 2'd2,
        REQ_LO = 2'd3
    } state_t;

    state_t state, state_nxt;

    // FIFO storage and pointers
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          empty, full, push, pop;

    // FSM datapath
    logic [CW-1:0] cnt, cnt_nxt;
    logic          lreq_nxt, load, tok_inc;

    // Lack synchronizer
    logic [SYNC_STAGES-1:0] sync;
    logic                   ack_s;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign ack_s    = sync[SYNC_STAGES-1];
    assign busy     = !empty || (state != IDLE);

    // FIFO data array; contents need no reset since reads are gated by count
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of 2)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Lack crosses in asynchronously; shift it through SYNC_STAGES flops
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], Lack};
        end
    end

    // FSM state register plus the registered handshake outputs and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            Lreq      <= 1'b0;
            Ldata     <= '0;
            tok_cnt   <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            Lreq  <= lreq_nxt;
            if (load) begin
                Ldata <= mem[rd_ptr];
            end
            if (tok_inc) begin
                tok_cnt <= tok_cnt + 16'd1;
            end
            if (ack_s && (state == IDLE || state == SETUP)) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Next-state logic: load head, hold data for the bundling margin, then run the 4-phase handshake
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lreq_nxt  = Lreq;
        load      = 1'b0;
        pop       = 1'b0;
        tok_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    load      = 1'b1;
                    pop       = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    lreq_nxt  = 1'b1;
                    state_nxt = REQ_HI;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    lreq_nxt  = 1'b0;
                    state_nxt = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    tok_inc   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef LREQ_TIMEOUT_EN
    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYC - 1);
    logic [31:0] wdog;

    // Watchdog: restarts when Lreq rises, counts while a handshake is open; flag only, never aborts
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog    <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == SETUP && state_nxt == REQ_HI) begin
                wdog <= '0;
            end else if (state == REQ_HI || state == REQ_LO) begin
                wdog <= wdog + 32'd1;
            end
            if ((state == REQ_HI || state == REQ_LO) && wdog == WDOG_LAST) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    // Watchdog not built; flag is constant low
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_async_lreq_source.sv
// Purpose: directed + randomized bench for async_lreq_source with a queue-based token model and an Lack responder.
// Latency: checks setup/sync timing from the stated cycle formulas at default parameters.
// Backpressure: exercises FIFO full, held producer words, and slow/random acknowledges.
module tb_async_lreq_source;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        Lreq;
    logic [7:0]  Ldata;
    logic        Lack = 1'b0;
    logic        busy;
    logic [15:0] tok_cnt;
    logic        proto_err;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int         pushed = 0;

    bit   auto_ack   = 1'b0;
    logic lack_force = 1'b0;
    int   dly        = 0;

    logic        prev_lreq = 1'b0;
    logic [15:0] prev_tok  = '0;
    int          tok_model = 0;
    bit          in_tok    = 1'b0;
    logic [7:0]  held      = '0;

    always #5 clk = ~clk;

    async_lreq_source dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .Lreq      (Lreq),
        .Ldata     (Ldata),
        .Lack      (Lack),
        .busy      (busy),
        .tok_cnt   (tok_cnt),
        .proto_err (proto_err),
        .timeout   (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word; the model records it only once the DUT shows room for it
    task automatic put(input logic [7:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 300) begin
            tick();
            n++;
        end
        chk("put_ready", 32'(in_ready), 32'd1);
        if (in_ready) begin
            exp_q.push_back(d);
            pushed++;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (tok_cnt != 16'(pushed) && n < 3000) begin
            tick();
            n++;
        end
        chk(tag, 32'(tok_cnt), 32'(pushed));
    endtask

    // Acknowledge environment: forced level, or follow Lreq after a random delay
    always @(posedge clk) begin
        #2;
        if (!auto_ack) begin
            Lack = lack_force;
        end else if (Lreq !== Lack) begin
            if (dly == 0) begin
                Lack = Lreq;
                dly  = $urandom_range(0, 4);
            end else begin
                dly--;
            end
        end
    end

    // Token monitor: data at Lreq rise must be the oldest accepted word and stay put until the token completes
    always @(negedge clk) begin
        if (rst) begin
            prev_lreq = 1'b0;
            prev_tok  = '0;
            tok_model = 0;
            in_tok    = 1'b0;
        end else begin
            if (Lreq && !prev_lreq) begin
                chk("token_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("token_data", 32'(Ldata), 32'(exp_q.pop_front()));
                end
                held   = Ldata;
                in_tok = 1'b1;
            end
            if (in_tok && Ldata !== held) begin
                chk("ldata_hold", 32'(Ldata), 32'(held));
            end
            if (tok_cnt !== prev_tok) begin
                tok_model++;
                chk("tok_cnt_step", 32'(tok_cnt), 32'(tok_model));
                chk("tok_after_req", 32'(in_tok), 32'd1);
                chk("tok_ldata", 32'(Ldata), 32'(held));
                in_tok = 1'b0;
            end
            prev_lreq = Lreq;
            prev_tok  = tok_cnt;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        int gap;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) tick();
        chk("rst_lreq",     32'(Lreq),      32'd0);
        chk("rst_ldata",    32'(Ldata),     32'd0);
        chk("rst_in_ready", 32'(in_ready),  32'd1);
        chk("rst_tok_cnt",  32'(tok_cnt),   32'd0);
        chk("rst_proto",    32'(proto_err), 32'd0);
        chk("rst_timeout",  32'(timeout),   32'd0);
        chk("rst_busy",     32'(busy),      32'd0);
        rst = 1'b0;
        tick();

        // Single token with exact latency
        put(8'hA5);
        in_data = 8'h5A;
        tick();
        chk("t1_ldata_c1", 32'(Ldata), 32'hA5);
        chk("t1_lreq_c1",  32'(Lreq),  32'd0);
        tick();
        chk("t1_lreq_c2",  32'(Lreq),  32'd0);
        tick();
        chk("t1_lreq_c3",  32'(Lreq),  32'd1);
        lack_force = 1'b1;
        tick();
        tick();
        chk("t1_ack_c2",   32'(Lreq),  32'd1);
        tick();
        chk("t1_ack_c3",   32'(Lreq),  32'd0);
        chk("t1_reqlo_ld", 32'(Ldata), 32'hA5);
        lack_force = 1'b0;
        tick();
        tick();
        chk("t1_tok_pre",  32'(tok_cnt), 32'd0);
        tick();
        chk("t1_tok_post", 32'(tok_cnt), 32'd1);
        chk("t1_busy",     32'(busy),    32'd0);

        // Fill the FIFO with Lack held low
        for (int i = 1; i <= 5; i++) begin
            put(8'(i));
        end
        chk("fill_ready", 32'(in_ready), 32'd0);
        chk("fill_busy",  32'(busy),     32'd1);
        in_valid = 1'b1;
        in_data  = 8'd6;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("full_hold", 32'(in_ready), 32'd0);
        end
        auto_ack = 1'b1;
        put(8'd6);
        wait_done("fill_done");
        chk("fill_q_empty", 32'(exp_q.size()), 32'd0);

        // Random words, gaps and acknowledge delays; in_data churns while idle
        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                in_data = 8'($urandom);
                tick();
            end
            put(8'($urandom));
        end
        wait_done("rand_done");
        chk("rand_q_empty", 32'(exp_q.size()), 32'd0);
        chk("rand_proto",   32'(proto_err),    32'd0);
        chk("rand_timeout", 32'(timeout),      32'd0);
        chk("rand_busy",    32'(busy),         32'd0);

        // Reset during REQ_HI with two words still buffered
        auto_ack   = 1'b0;
        lack_force = 1'b0;
        tick();
        tick();
        put(8'h11);
        put(8'h22);
        put(8'h33);
        n = 0;
        while (!Lreq && n < 20) begin
            tick();
            n++;
        end
        chk("mid_lreq", 32'(Lreq), 32'd1);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_lreq",  32'(Lreq),     32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_tok",   32'(tok_cnt),  32'd0);
        chk("mid_rst_busy",  32'(busy),     32'd0);
        exp_q.delete();
        pushed = 0;
        rst    = 1'b0;
        tick();

        // Spurious acknowledge while idle
        chk("pe_idle", 32'(proto_err), 32'd0);
        lack_force = 1'b1;
        tick();
        tick();
        chk("pe_c2", 32'(proto_err), 32'd0);
        tick();
        chk("pe_c3", 32'(proto_err), 32'd1);
        lack_force = 1'b0;
        repeat (5) tick();
        chk("pe_sticky", 32'(proto_err), 32'd1);
        chk("pe_busy",   32'(busy),      32'd0);
        rst = 1'b1;
        tick();
        chk("pe_cleared", 32'(proto_err), 32'd0);
        rst = 1'b0;
        tick();

        // One clean token after all the resets
        auto_ack = 1'b1;
        put(8'h3C);
        wait_done("post_rst_tok");
        chk("final_timeout", 32'(timeout),   32'd0);
        chk("final_proto",   32'(proto_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
